count_sched: RTL

COUNT_SCHED -- requirements
Module: count_sched

---
 rtl/count_sched_pkg.sv | 37 +++
 rtl/count_increase.sv | 21 ++
 rtl/count_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/count_sched_pkg.sv
// Shared types and helpers for the count_sched round-robin counter scheduler.
// Optional saturation is selected with the COUNT_SAT_EN macro in count_sched.sv.
package count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 8;

  // Widest request vector the pick function accepts.
  localparam int RR_MAX = 32;
  localparam int RR_IW  = $clog2(RR_MAX);

  // First set bit of req[n-1:0], searching upward from last+1 and wrapping.
  // Returns last when nothing is set; callers qualify with |req.
  function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int n, input int last);
    int   idx;
    logic found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= RR_MAX; i++) begin
      if (i <= n) begin
        idx = last + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[RR_IW-1:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/count_increase.sv
// Shared single-cycle incrementer: out is in + enb, registered once.
module count_increase #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] in_i,
  input  logic             enb_i,
  output logic [CNT_W-1:0] out_o
);

  logic [CNT_W-1:0] out_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) out_q <= '0;
    else       out_q <= in_i + {{(CNT_W-1){1'b0}}, enb_i};
  end

  assign out_o = out_q;

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one incrementer across NUM_REQ counters.
// Define COUNT_SAT_EN to saturate at all-ones and expose the sat flag.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         clr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic [CNT_W-1:0]           done_cnt,
  output logic                       busy,
  input  logic [$clog2(NUM_REQ)-1:0] rd_sel,
  output logic [CNT_W-1:0]           rd_cnt
`ifdef COUNT_SAT_EN
 ,output logic                       sat
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  state_e                          state_q, state_d;
  logic [IDW-1:0]                  cur_id_q, cur_id_d;
  logic [IDW-1:0]                  last_id_q, last_id_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]                inc_in, inc_out;
  logic                            inc_enb;
  logic                            at_max;

  assign inc_in = cnt_q[cur_id_q];
  assign at_max = (inc_in == {CNT_W{1'b1}});

  count_increase #(.CNT_W(CNT_W)) u_inc (
    .clk_i (clk),
    .rst_i (~rst),
    .in_i  (inc_in),
    .enb_i (inc_enb),
    .out_o (inc_out)
  );

  // FSM state and arbitration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cur_id_q  <= '0;
      last_id_q <= IDW'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      last_id_q <= last_id_d;
    end
  end

  // Next state; the WB hand-off searches from cur_id because last_id takes it now
  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    last_id_d = last_id_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = ISSUE;
          cur_id_d = IDW'(rr_pick(RR_MAX'(req), NUM_REQ, int'(last_id_q)));
        end
      end
      ISSUE: state_d = WB;
      WB: begin
        last_id_d = cur_id_q;
        if (|req) begin
          state_d  = ISSUE;
          cur_id_d = IDW'(rr_pick(RR_MAX'(req), NUM_REQ, int'(cur_id_q)));
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    gnt     = '0;
    inc_enb = 1'b0;
    if (state_q == ISSUE) begin
      gnt[cur_id_q] = 1'b1;
`ifdef COUNT_SAT_EN
      inc_enb = ~at_max;
`else
      inc_enb = 1'b1;
`endif
    end
  end

  assign done     = (state_q == WB);
  assign done_id  = cur_id_q;
  assign done_cnt = inc_out;
  assign busy     = (state_q != IDLE);
  assign rd_cnt   = cnt_q[rd_sel];

  // Counter bank: clear beats a same-cycle writeback
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == WB) cnt_d[cur_id_q] = inc_out;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (clr[i]) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

`ifdef COUNT_SAT_EN
  logic sat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   sat_q <= 1'b0;
    else if (state_q == ISSUE)  sat_q <= at_max;
  end

  assign sat = done & sat_q;
`else
  logic unused_at_max;
  assign unused_at_max = at_max;
`endif

endmodule
